// File: rtl/instruction_processor_pkg.sv
// Shared encodings for the IP-local instruction processor: word classes,
// ALU opcodes, condition codes, register indices and the forwarded NOP.
package instruction_processor_pkg;

  localparam logic [1:0]  CLASS_ALU = 2'b01;
  localparam logic [4:0]  OP_FWD    = 5'b00000;
  localparam logic [4:0]  OP_JMP    = 5'b00001;
  localparam logic [4:0]  OP_MOVH   = 5'b00010;
  localparam logic [4:0]  OP_MOVL   = 5'b00011;

  localparam logic [2:0]  SP_IDX    = 3'd6;
  localparam logic [2:0]  IP_IDX    = 3'd7;

  // addnv r0,r0 in core encoding
  localparam logic [14:0] NOP_WORD  = 15'h42C0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_MUL = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_MOV = 4'b0110,
    ALU_CMP = 4'b0111
  } alu_op_e;

  localparam logic [3:0] COND_Z  = 4'b0000;
  localparam logic [3:0] COND_NZ = 4'b0001;
  localparam logic [3:0] COND_C  = 4'b0010;
  localparam logic [3:0] COND_NC = 4'b0011;
  localparam logic [3:0] COND_N  = 4'b0100;
  localparam logic [3:0] COND_NN = 4'b0101;
  localparam logic [3:0] COND_AL = 4'b1010;
  localparam logic [3:0] COND_NV = 4'b1011;

  typedef struct packed {
    logic [1:0] cls;
    logic [3:0] op;
    logic [3:0] cond;
    logic [2:0] dst;
    logic [2:0] src;
  } alu_word_t;

  function automatic logic cond_met(input logic [3:0] cond,
                                    input logic z, input logic n, input logic c);
    case (cond)
      COND_Z:  cond_met = z;
      COND_NZ: cond_met = ~z;
      COND_C:  cond_met = c;
      COND_NC: cond_met = ~c;
      COND_N:  cond_met = n;
      COND_NN: cond_met = ~n;
      COND_AL: cond_met = 1'b1;
      COND_NV: cond_met = 1'b0;
      default: cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ip_alu.sv
// Combinational ALU for IP-local arithmetic words: result plus Z/N/C and
// whether the op executes at all / writes its destination.
module ip_alu
  import instruction_processor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             executes,
  output logic             writes
);

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    result = '0;
    flag_c = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        flag_c = sum[WIDTH];
      end
      ALU_SUB, ALU_CMP: begin
        // top bit of the widened difference is the borrow
        result = diff[WIDTH-1:0];
        flag_c = diff[WIDTH];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_MUL: begin
        result = prod[WIDTH-1:0];
        flag_c = |prod[2*WIDTH-1:WIDTH];
      end
      ALU_XOR: result = a ^ b;
      ALU_MOV: result = b;
      default: result = '0;
    endcase
  end

  assign flag_z   = (result == '0);
  assign flag_n   = result[WIDTH-1];
  assign executes = ~op[3];
  assign writes   = ~op[3] && (op != ALU_CMP);

endmodule

// File: rtl/instruction_processor.sv
// Instruction pre-decoder: owns R0-R7 (R6=SP, R7=IP), executes IP-local words
// itself and forwards core / memory words, substituting NOP for local ones.
module instruction_processor
  import instruction_processor_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int REGS_CODING = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       regData,
  input  logic [REGS_CODING-1:0] regChoose,
  input  logic [WIDTH-1:0]       ROMData,
  output logic [WIDTH-2:0]       instructionOut,
  output logic [WIDTH-1:0]       ROMAddress
);

  logic [WIDTH-1:0] regs [REGS_CODING];
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  alu_word_t        word;
  logic [4:0]       opcode5;
  logic [2:0]       mv_idx;
  logic [WIDTH-1:0] mv_val;
  logic             is_fwd;

  logic [WIDTH-1:0] alu_result;
  logic             alu_z;
  logic             alu_n;
  logic             alu_c;
  logic             alu_executes;
  logic             alu_writes;

  logic             int_we;
  logic [2:0]       int_idx;
  logic [WIDTH-1:0] int_data;
  logic             flag_we;

  assign word    = alu_word_t'(ROMData);
  assign opcode5 = ROMData[WIDTH-1:WIDTH-5];
  assign mv_idx  = ROMData[10:8];
  assign mv_val  = regs[mv_idx];

  assign ROMAddress = regs[IP_IDX];

  // Core words (msb set) and the memory/transfer group pass straight through
  assign is_fwd         = ROMData[WIDTH-1] || (opcode5 == OP_FWD);
  assign instructionOut = is_fwd ? ROMData[WIDTH-2:0] : NOP_WORD;

  ip_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op       (word.op),
    .a        (regs[word.dst]),
    .b        (regs[word.src]),
    .result   (alu_result),
    .flag_z   (alu_z),
    .flag_n   (alu_n),
    .flag_c   (alu_c),
    .executes (alu_executes),
    .writes   (alu_writes)
  );

  always_comb begin
    int_we   = 1'b0;
    int_idx  = word.dst;
    int_data = alu_result;
    flag_we  = 1'b0;
    if (word.cls == CLASS_ALU) begin
      if (alu_executes && cond_met(word.cond, flag_z, flag_n, flag_c)) begin
        flag_we = 1'b1;
        int_we  = alu_writes;
      end
    end else begin
      case (opcode5)
        OP_MOVL: begin
          int_we   = 1'b1;
          int_idx  = mv_idx;
          int_data = {mv_val[WIDTH-1:8], ROMData[7:0]};
        end
        OP_MOVH: begin
          int_we   = 1'b1;
          int_idx  = mv_idx;
          int_data = {ROMData[7:0], mv_val[7:0]};
        end
        OP_JMP: begin
          int_we   = 1'b1;
          int_idx  = IP_IDX;
          int_data = mv_val;
        end
        default: int_we = 1'b0;
      endcase
    end
  end

  // Priority per register: external write, then internal write, then IP increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS_CODING; i++) regs[i] <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      for (int i = 0; i < REGS_CODING; i++) begin
        if (regChoose[i]) begin
          regs[i] <= regData;
        end else if (int_we && (int_idx == 3'(i))) begin
          regs[i] <= int_data;
        end else if (IP_IDX == 3'(i)) begin
          regs[i] <= regs[i] + WIDTH'(1);
        end
      end
      if (flag_we) begin
        flag_z <= alu_z;
        flag_n <= alu_n;
        flag_c <= alu_c;
      end
    end
  end

endmodule

// File: tb/tb_instruction_processor.sv
// Directed and randomized bench for instruction_processor against a
// word-level reference model of the register file and flags.
module tb_instruction_processor;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] regData;
  logic [7:0]  regChoose;
  logic [15:0] ROMData;
  logic [14:0] instructionOut;
  logic [15:0] ROMAddress;

  localparam logic [15:0] NOP16 = 16'h42C0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_r [8];
  logic        m_z, m_n, m_c;

  instruction_processor #(
    .WIDTH       (16),
    .REGS_CODING (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .regData        (regData),
    .regChoose      (regChoose),
    .ROMData        (ROMData),
    .instructionOut (instructionOut),
    .ROMAddress     (ROMAddress)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [14:0] exp_out(input logic [15:0] w);
    if (w[15] || w[15:11] == 5'b00000) return w[14:0];
    return 15'h42C0;
  endfunction

  function automatic bit cond_ok(input int cc);
    case (cc)
      0:  return m_z;
      1:  return !m_z;
      2:  return m_c;
      3:  return !m_c;
      4:  return m_n;
      5:  return !m_n;
      10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Next-state of the architectural registers for one clock edge
  task automatic model_edge(input logic [15:0] rom, input logic [7:0] rc, input logic [15:0] rd);
    logic [15:0] nxt [8];
    longint a, b, full;
    int op, cc, d, s, t;
    bit carry;
    nxt = m_r;
    nxt[7] = m_r[7] + 16'd1;
    if (rom[15:14] == 2'b01) begin
      op = int'(rom[13:10]); cc = int'(rom[9:6]);
      d  = int'(rom[5:3]);   s  = int'(rom[2:0]);
      a  = longint'(m_r[d]); b  = longint'(m_r[s]);
      if (op < 8 && cond_ok(cc)) begin
        carry = 1'b0;
        case (op)
          0: begin full = a + b; carry = (full > 65535); end
          1, 7: begin full = a - b; carry = (a < b); end
          2: full = a & b;
          3: full = a | b;
          4: begin full = a * b; carry = (full > 65535); end
          5: full = a ^ b;
          default: full = b;
        endcase
        m_z = (full[15:0] == 16'd0);
        m_n = full[15];
        m_c = carry;
        if (op != 7) nxt[d] = full[15:0];
      end
    end else begin
      t = int'(rom[10:8]);
      case (rom[15:11])
        5'b00011: nxt[t] = {m_r[t][15:8], rom[7:0]};
        5'b00010: nxt[t] = {rom[7:0], m_r[t][7:0]};
        5'b00001: nxt[7] = m_r[t];
        default: ;
      endcase
    end
    for (int i = 0; i < 8; i++) if (rc[i]) nxt[i] = rd;
    m_r = nxt;
  endtask

  task automatic step(input logic [15:0] rom, input logic [7:0] rc, input logic [15:0] rd);
    ROMData = rom; regChoose = rc; regData = rd;
    #1;
    check("instr_out", instructionOut, exp_out(rom));
    check("rom_addr", ROMAddress, m_r[7]);
    model_edge(rom, rc, rd);
    @(posedge clock);
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("r%0d", i), dut.regs[i], m_r[i]);
    check("flags_znc", {dut.flag_z, dut.flag_n, dut.flag_c}, {m_z, m_n, m_c});
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    logic [3:0]  op, cc;
    int k;
    w = 16'($urandom);
    case ($urandom_range(0, 5))
      0: w[15] = 1'b1;
      1: w[15:11] = 5'b00000;
      2: begin
        op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
        k  = $urandom_range(0, 8);
        cc = (k < 6) ? 4'(k) : (k < 8 ? 4'd10 : 4'($urandom_range(11, 15)));
        w[15:14] = 2'b01; w[13:10] = op; w[9:6] = cc;
      end
      3: w[15:11] = 5'($urandom_range(1, 3));
      4: w[15:13] = 3'b001;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    reset = 1'b0; ROMData = 16'hC281; regChoose = 8'h00; regData = 16'h0000;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;

    #2;
    check("rst_addr", ROMAddress, 16'h0000);
    check("core_c281", instructionOut, 15'h4281);
    ROMData = 16'hA9FE; #1;
    check("core_a9fe", instructionOut, 15'h29FE);
    regChoose = 8'hFF; regData = 16'h5555;
    @(posedge clock); #1;
    check("rst_hold_addr", ROMAddress, 16'h0000);
    check("rst_hold_r3", dut.regs[3], 16'h0000);
    reset = 1'b1;

    for (int k = 0; k < 3; k++) begin
      step(NOP16, 8'h00, 16'h0000);
      check("idle_ip", ROMAddress, 16'(k + 1));
    end

    step(NOP16, 8'h80, 16'h0000);
    check("ip_ext_zero", ROMAddress, 16'h0000);
    step(NOP16, 8'h00, 16'h0000);
    check("ip_after_ext", ROMAddress, 16'h0001);

    step(NOP16, 8'h80, 16'hFFFF);
    check("ip_top", ROMAddress, 16'hFFFF);
    step(NOP16, 8'h00, 16'h0000);
    check("ip_wrap", ROMAddress, 16'h0000);

    step(NOP16, 8'h04, 16'd10);
    step(NOP16, 8'h40, 16'hFFFF);
    check("r2_ext", dut.regs[2], 16'd10);
    check("sp_ext", dut.regs[6], 16'hFFFF);

    step(NOP16, 8'h01, 16'd13);
    step(16'h4282, 8'h00, 16'h0000);
    check("add_r0_23", dut.regs[0], 16'd23);
    check("add_nop_out", instructionOut, 15'h42C0);
    step(16'h4282, 8'h00, 16'h0000);
    check("add_r0_33", dut.regs[0], 16'd33);
    step(16'h5282, 8'h00, 16'h0000);
    check("mul_r0_330", dut.regs[0], 16'd330);
    check("mul_nop_out", instructionOut, 15'h42C0);

    step(16'h1AFC, 8'h00, 16'h0000);
    check("movl_r2", dut.regs[2], 16'h00FC);

    step(16'h4282, 8'h01, 16'h1234);
    check("ext_beats_alu", dut.regs[0], 16'h1234);

    step(16'h4690, 8'h00, 16'h0000);
    check("sub_r2", dut.regs[2], 16'hEEC8);
    check("sub_flags", {dut.flag_z, dut.flag_n, dut.flag_c}, 3'b011);
    step(16'h46D0, 8'h00, 16'h0000);
    check("never_r2", dut.regs[2], 16'hEEC8);
    check("never_flags", {dut.flag_z, dut.flag_n, dut.flag_c}, 3'b011);

    for (int k = 0; k < 2000; k++) begin
      step(rand_word(),
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
           16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
